// File: rtl/rx_comando_pkg.sv
// Shared definitions for the serial valve-command receiver: FSM state
// encodings (also exported on db_estado) and the ASCII command bytes.
package rx_comando_pkg;

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    INICIO   = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    PARADA   = 4'd4,
    ENTREGA  = 4'd5,
    ERRO     = 4'd6
  } estado_t;

  localparam logic [7:0] CMD_MANUAL = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_AUTO   = 8'h41;  // 'A'
  localparam logic [7:0] CMD_ABRE   = 8'h31;  // '1'
  localparam logic [7:0] CMD_FECHA  = 8'h30;  // '0'

endpackage

// File: rtl/rx_serial_uart.sv
// UART deserialiser: 2-flop synchroniser, bit timer, receive FSM and framing
// check. Frame is 8N1 by default, 7E1 when RX_PARIDADE_EN is defined.
module rx_serial_uart
  import rx_comando_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  output logic [7:0] dado,
  output logic       dado_valido,
  output logic       erro_quadro,
  output logic [3:0] db_estado
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_MEIO = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FIM  = TW'(CLKS_PER_BIT - 1);
`ifdef RX_PARIDADE_EN
  localparam logic [2:0] ULTIMO_BIT = 3'd6;
`else
  localparam logic [2:0] ULTIMO_BIT = 3'd7;
`endif

  logic          rx_meta, rx_s;
  estado_t       estado;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          paridade_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

`ifdef RX_PARIDADE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      paridade_ok <= 1'b0;
    else if (estado == PARIDADE && timer == T_FIM)
      paridade_ok <= ((^shift[6:0]) == rx_s);
  end
`else
  assign paridade_ok = 1'b1;
`endif

  // Timer free-runs modulo CLKS_PER_BIT and is zeroed on every state change,
  // so each state measures from its own entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= OCIOSO;
      timer       <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      dado        <= '0;
      dado_valido <= 1'b0;
      erro_quadro <= 1'b0;
    end else begin
      dado_valido <= 1'b0;
      erro_quadro <= 1'b0;
      timer       <= (timer == T_FIM) ? '0 : timer + 1'b1;
      case (estado)
        OCIOSO: begin
          timer <= '0;
          if (!rx_s) begin
            estado  <= INICIO;
            bit_idx <= '0;
            shift   <= '0;
          end
        end
        INICIO: begin
          if (timer == T_MEIO) begin
            timer  <= '0;
            estado <= rx_s ? OCIOSO : DADOS;
          end
        end
        DADOS: begin
          if (timer == T_FIM) begin
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == ULTIMO_BIT) begin
`ifdef RX_PARIDADE_EN
              estado <= PARIDADE;
`else
              estado <= PARADA;
`endif
            end
          end
        end
`ifdef RX_PARIDADE_EN
        PARIDADE: begin
          if (timer == T_FIM) estado <= PARADA;
        end
`endif
        PARADA: begin
          if (timer == T_FIM) begin
            if (rx_s && paridade_ok) begin
              estado      <= ENTREGA;
              dado        <= shift;
              dado_valido <= 1'b1;
            end else begin
              estado      <= ERRO;
              erro_quadro <= 1'b1;
            end
          end
        end
        ENTREGA: begin
          timer  <= '0;
          estado <= OCIOSO;
        end
        ERRO: begin
          timer <= '0;
          if (rx_s) estado <= OCIOSO;
        end
        default: begin
          timer  <= '0;
          estado <= OCIOSO;
        end
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: rtl/rx_comando_valvula.sv
// Serial valve-command receiver: UART front end plus the command decoder
// that owns manual / abre_manual. Optional 7E1 framing via RX_PARIDADE_EN.
module rx_comando_valvula
  import rx_comando_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  input  logic       zera_vlv,
  output logic       manual,
  output logic       abre_manual,
  output logic [7:0] dado,
  output logic       dado_valido,
  output logic       erro_quadro,
  output logic [3:0] db_estado
);

  rx_serial_uart #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clock      (clock),
    .reset      (reset),
    .RX         (RX),
    .dado       (dado),
    .dado_valido(dado_valido),
    .erro_quadro(erro_quadro),
    .db_estado  (db_estado)
  );

  // abre_manual may only rise while manual is set, keeping abre_manual -> manual.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      manual      <= 1'b0;
      abre_manual <= 1'b0;
    end else if (zera_vlv) begin
      manual      <= 1'b0;
      abre_manual <= 1'b0;
    end else if (dado_valido) begin
      case (dado)
        CMD_MANUAL: manual <= 1'b1;
        CMD_AUTO: begin
          manual      <= 1'b0;
          abre_manual <= 1'b0;
        end
        CMD_ABRE:  if (manual) abre_manual <= 1'b1;
        CMD_FECHA: if (manual) abre_manual <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_comando_valvula.sv
// Scoreboard bench for rx_comando_valvula at CLKS_PER_BIT=16; covers the 7E1
// build too when RX_PARIDADE_EN is defined.
module tb_rx_comando_valvula;

  localparam int unsigned CPB = 16;
`ifdef RX_PARIDADE_EN
  localparam int unsigned NBITS = 7;
`else
  localparam int unsigned NBITS = 8;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       RX;
  logic       zera_vlv;
  logic       manual, abre_manual;
  logic [7:0] dado;
  logic       dado_valido, erro_quadro;
  logic [3:0] db_estado;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         erro;
    logic [7:0] dado;
    logic       manual;
    logic       abre;
  } exp_t;

  exp_t q[$];

  rx_comando_valvula #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .RX         (RX),
    .zera_vlv   (zera_vlv),
    .manual     (manual),
    .abre_manual(abre_manual),
    .dado       (dado),
    .dado_valido(dado_valido),
    .erro_quadro(erro_quadro),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic esperar(input bit erro, input logic [7:0] d, input logic m, input logic a);
    exp_t e;
    e.erro = erro; e.dado = d; e.manual = m; e.abre = a;
    q.push_back(e);
  endtask

  // Start, data LSB first, optional parity, stop held for stop_len cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic par_flip, input int unsigned stop_len);
    RX = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int unsigned i = 0; i < NBITS; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clock);
    end
`ifdef RX_PARIDADE_EN
    RX = (^b[6:0]) ^ par_flip;
    repeat (CPB) @(negedge clock);
`endif
    RX = stop;
    repeat (stop_len) @(negedge clock);
  endtask

  task automatic cmd(input logic [7:0] b, input logic m, input logic a);
    esperar(1'b0, b, m, a);
    send_frame(b, 1'b1, 1'b0, CPB);
    RX = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  // Monitor: every pulse pops one expectation; decoder effect checked a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && (dado_valido || erro_quadro)) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: dado_valido=%0b erro_quadro=%0b dado=%0h, expected no pulse",
                   dado_valido, erro_quadro, dado);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", 32'({dado_valido, erro_quadro}), e.erro ? 32'h1 : 32'h2);
          chk("dado", 32'(dado), 32'(e.dado));
          @(negedge clock);
          chk("pulse_width", 32'({dado_valido, erro_quadro}), 32'h0);
          chk("manual", 32'(manual), 32'(e.manual));
          chk("abre_manual", 32'(abre_manual), 32'(e.abre));
        end
      end
    end
  end

  initial begin
    RX = 1'b1;
    zera_vlv = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_manual", 32'(manual), 32'h0);
    chk("rst_abre", 32'(abre_manual), 32'h0);
    chk("rst_dado", 32'(dado), 32'h0);
    chk("rst_pulses", 32'({dado_valido, erro_quadro}), 32'h0);
    chk("rst_estado", 32'(db_estado), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // '1' while automatic: accepted byte, no valve change
    cmd(8'h31, 1'b0, 1'b0);

    // 'M' then '1' back to back (next start right after the stop midpoint)
    esperar(1'b0, 8'h4D, 1'b1, 1'b0);
    send_frame(8'h4D, 1'b1, 1'b0, 10);
    esperar(1'b0, 8'h31, 1'b1, 1'b1);
    send_frame(8'h31, 1'b1, 1'b0, CPB);
    RX = 1'b1;
    repeat (8) @(negedge clock);

    // Stop bit 0, line held low (break): error, dado kept, stay in ERRO
    esperar(1'b1, 8'h31, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, CPB);
    repeat (3 * CPB) @(negedge clock);
    chk("erro_hold", 32'(db_estado), 32'h6);
    RX = 1'b1;
    repeat (4) @(negedge clock);
    chk("erro_exit", 32'(db_estado), 32'h0);

    // 4-cycle glitch: INICIO then back to OCIOSO, no pulses
    RX = 1'b0;
    repeat (4) @(negedge clock);
    chk("glitch_inicio", 32'(db_estado), 32'h1);
    RX = 1'b1;
    repeat (20) @(negedge clock);
    chk("glitch_ocioso", 32'(db_estado), 32'h0);

    // zera_vlv coincident with a decoded '1' wins
    esperar(1'b0, 8'h31, 1'b0, 1'b0);
    fork
      send_frame(8'h31, 1'b1, 1'b0, CPB);
      begin
        for (int i = 0; i < 400 && !dado_valido; i++) @(negedge clock);
        chk("zera_sync", 32'(dado_valido), 32'h1);
        zera_vlv = 1'b1;
        @(negedge clock);
        zera_vlv = 1'b0;
      end
    join
    RX = 1'b1;
    repeat (8) @(negedge clock);

    // Reset during DADOS clears everything; next frame received cleanly
    cmd(8'h4D, 1'b1, 1'b0);
    RX = 1'b0;
    repeat (CPB + 40) @(negedge clock);
    chk("mid_dados", 32'(db_estado), 32'h2);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_manual", 32'(manual), 32'h0);
    chk("mid_rst_dado", 32'(dado), 32'h0);
    chk("mid_rst_estado", 32'(db_estado), 32'h0);
    chk("mid_rst_pulses", 32'({dado_valido, erro_quadro}), 32'h0);
    RX = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    cmd(8'h41, 1'b0, 1'b0);

    // Full command walk including an unknown byte
    cmd(8'h4D, 1'b1, 1'b0);
    cmd(8'h31, 1'b1, 1'b1);
    cmd(8'h5A, 1'b1, 1'b1);
    cmd(8'h30, 1'b1, 1'b0);
    cmd(8'h31, 1'b1, 1'b1);
    cmd(8'h41, 1'b0, 1'b0);

`ifdef RX_PARIDADE_EN
    // Parity: wrong parity -> error, state kept; correct parity -> decoded
    cmd(8'h4D, 1'b1, 1'b0);
    esperar(1'b1, 8'h4D, 1'b1, 1'b0);
    send_frame(8'h31, 1'b1, 1'b1, CPB);
    RX = 1'b1;
    repeat (8) @(negedge clock);
    cmd(8'h31, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clock);
    chk("queue_drained", 32'(q.size()), 32'h0);
    repeat (10) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rx_comando_valvula.md
# rx_comando_valvula

Serial command receiver for the tank controller's RX line: the inbound counterpart of the measurement transmitter that drives saida_serial. Deserialises asynchronous UART frames, checks framing, and decodes single-byte ASCII commands into the manual-mode flag and manual valve request consumed by the valve logic in the datapath. The control unit's zera_vlv clears manual state.

## Interface
- CLKS_PER_BIT, 434: clock cycles per bit (50 MHz / 115200); minimum 8.
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- RX  in  1  serial line, idle high, asynchronous to clock
- zera_vlv  in  1  synchronous clear of manual and abre_manual
- manual  out  1  1 = valve under serial (manual) control
- abre_manual  out  1  manual valve request, 1 = open
- dado  out  8  last accepted byte (bit 7 = 0 when RX_PARIDADE_EN)
- dado_valido  out  1  one-cycle pulse, dado updated
- erro_quadro  out  1  one-cycle pulse on framing or parity error
- db_estado  out  4  receiver FSM state

## Operation
- Reset: all outputs 0; synchroniser flops 1; FSM OCIOSO.
- RX passes a 2-flop synchroniser; all logic uses synchronised value rx_s.
- FSM states:
  - OCIOSO: rx_s = 0 -> INICIO, clear bit counter.
  - INICIO: wait CLKS_PER_BIT/2 cycles; sample rx_s; 0 -> DADOS, 1 -> OCIOSO (glitch rejected, no error).
  - DADOS: every CLKS_PER_BIT cycles sample one bit, LSB first, into shift register; after last data bit -> PARIDADE (macro) or PARADA.
  - PARIDADE: one bit-time, sample parity bit.
  - PARADA: one bit-time, sample stop bit. 1 and parity ok -> ENTREGA; otherwise -> ERRO.
  - ENTREGA: one cycle; load dado, pulse dado_valido, run decoder -> OCIOSO.
  - ERRO: pulse erro_quadro on entry; stay until rx_s = 1 (break tolerance) -> OCIOSO. dado unchanged, no decode.
- Decoder (acts only in ENTREGA):
  - 0x4D 'M': manual <= 1 (abre_manual unchanged).
  - 0x41 'A': manual <= 0, abre_manual <= 0.
  - 0x31 '1': abre_manual <= 1 only if manual = 1.
  - 0x30 '0': abre_manual <= 0 only if manual = 1.
  - any other byte: no change.
- Invariant: abre_manual = 1 implies manual = 1.
- zera_vlv = 1: manual <= 0, abre_manual <= 0; wins over a decode in the same cycle. Receiver FSM unaffected.

## Timing
- Bit timer counts 0..CLKS_PER_BIT-1, restarts on each state change; width clog2(CLKS_PER_BIT).
- Start detection: 2 cycles after RX falls (synchroniser).
- Bit n (0-based data) sampled CLKS_PER_BIT/2 + (n+1)*CLKS_PER_BIT cycles after start detection.
- dado_valido / erro_quadro: exactly one cycle, asserted the cycle after stop-bit sample.
- manual / abre_manual change on the clock edge ending the dado_valido cycle (visible 1 cycle after pulse).
- Back-to-back frames: a start bit beginning immediately after the stop-bit midpoint is received without loss.
- Reset mid-frame: frame discarded, no pulses; next falling edge starts fresh.

## Configuration
- RX_PARIDADE_EN defined: frame 7E1 (start, 7 data, even parity, 1 stop); dado[7] = 0; parity mismatch -> ERRO path.
- Undefined: frame 8N1; PARIDADE state absent from the FSM.
- Command codes identical in both modes.

## Structure
- Package rx_comando_pkg: state enum with fixed 4-bit encodings (OCIOSO=0, INICIO=1, DADOS=2, PARIDADE=3, PARADA=4, ENTREGA=5, ERRO=6) and command byte constants CMD_MANUAL, CMD_AUTO, CMD_ABRE, CMD_FECHA.
- Sub-module rx_serial_uart: synchroniser, bit timer, FSM, shift register, framing/parity check; outputs dado, dado_valido, erro_quadro, db_estado. Decoder and manual/abre_manual registers live in rx_comando_valvula.

## Test plan
- CLKS_PER_BIT=16; send 'M' then '1' -> two dado_valido pulses, dado=0x4D then 0x31; manual=1, abre_manual=1 one cycle after second pulse.
- manual=0, send '1' -> dado_valido, dado=0x31, abre_manual stays 0.
- Frame with stop bit 0 -> erro_quadro one pulse, no dado_valido, dado unchanged; RX held low 3 bit-times, FSM stays ERRO until RX high.
- RX low pulse of 4 cycles -> FSM returns OCIOSO, no pulses; manual=1, abre_manual=1, zera_vlv coincident with decoded '1' -> both 0.
- Reset asserted during DADOS -> all outputs 0 immediately; following 0x41 frame received correctly.
- RX_PARIDADE_EN: 0x31 with odd parity bit -> erro_quadro, abre_manual unchanged; correct parity -> dado=0x31.
